// File: rtl/sleep_timer.sv
// sleep_timer
//   Lockout timer between the Controller's sleep output and its end_sleep
//   input. While sleep is held high it counts down a lockout of whole seconds
//   of clk, then pulses end_sleep for one cycle. Each completed lockout doubles
//   the next one, saturating at MAX_LEVEL; correct_password clears escalation.
//
// Ports
//   clk              in   system clock
//   system_reset     in   synchronous, active-high reset
//   sleep            in   level from Controller, high while it is asleep
//   correct_password in   one-cycle pulse, clears the escalation level
//   end_sleep        out  registered one-cycle pulse, lockout elapsed
//   sleeping         out  high while the countdown runs
//   secs_left        out  remaining whole seconds, 0 when not counting
//   lock_level       out  current escalation level
//
// state        | meaning
// IDLE         | waiting for sleep to rise
// COUNT        | countdown running
// WAIT_RELEASE | lockout done, waiting for sleep to drop before re-arming

module sleep_timer #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BASE_SECONDS = 5,
  parameter int MAX_LEVEL    = 3,
  parameter int SEC_W        = 8,
  localparam int LVL_RAW     = $clog2(MAX_LEVEL + 1),
  localparam int LVL_W       = (LVL_RAW < 2) ? 2 : LVL_RAW
) (
  input  logic             clk,
  input  logic             system_reset,
  input  logic             sleep,
  input  logic             correct_password,
  output logic             end_sleep,
  output logic             sleeping,
  output logic [SEC_W-1:0] secs_left,
  output logic [LVL_W-1:0] lock_level
);

  localparam int PS_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PS_W-1:0]  PS_MAX  = PS_W'(CLK_HZ - 1);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(MAX_LEVEL);
  localparam logic [SEC_W-1:0] BASE    = SEC_W'(BASE_SECONDS);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    COUNT        = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PS_W-1:0]  ps_q, ps_d;
  logic [SEC_W-1:0] secs_q, secs_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic             end_q, end_d;
  logic             sleeping_q, sleeping_d;
  logic             tick;

  assign tick = (ps_q == PS_MAX);

  always_comb begin
    state_d = state_q;
    ps_d    = ps_q;
    secs_d  = secs_q;
    lvl_d   = lvl_q;
    end_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (sleep) begin
          state_d = COUNT;
          secs_d  = BASE << lvl_q;
          ps_d    = '0;
        end
      end

      COUNT: begin
        // Abort takes priority over a coincident expiry: no pulse if sleep drops.
        if (!sleep) begin
          state_d = IDLE;
          secs_d  = '0;
          ps_d    = '0;
        end else begin
          ps_d = tick ? '0 : ps_q + 1'b1;
          if (tick && (secs_q != '0)) begin
            if (secs_q == SEC_W'(1)) begin
              secs_d  = '0;
              end_d   = 1'b1;
              state_d = WAIT_RELEASE;
              if (lvl_q < LVL_MAX) lvl_d = lvl_q + 1'b1;
            end else begin
              secs_d = secs_q - 1'b1;
            end
          end
        end
      end

      WAIT_RELEASE: begin
        if (!sleep) state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        secs_d  = '0;
        ps_d    = '0;
      end
    endcase

    // Clear wins over a same-cycle expiry increment.
    if (correct_password) lvl_d = '0;

    sleeping_d = (state_d == COUNT);
  end

  always_ff @(posedge clk) begin
    if (system_reset) begin
      state_q    <= IDLE;
      ps_q       <= '0;
      secs_q     <= '0;
      lvl_q      <= '0;
      end_q      <= 1'b0;
      sleeping_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ps_q       <= ps_d;
      secs_q     <= secs_d;
      lvl_q      <= lvl_d;
      end_q      <= end_d;
      sleeping_q <= sleeping_d;
    end
  end

  assign end_sleep  = end_q;
  assign sleeping   = sleeping_q;
  assign secs_left  = secs_q;
  assign lock_level = lvl_q;

endmodule

// File: tb/tb_sleep_timer.sv
module tb_sleep_timer;

  logic       clk;
  logic       system_reset;
  logic       sleep;
  logic       correct_password;
  logic       end_sleep;
  logic       sleeping;
  logic [7:0] secs_left;
  logic [1:0] lock_level;

  int total_cnt;
  int pass_cnt;
  int fail_cnt;
  int pulses;

  sleep_timer #(
    .CLK_HZ(4),
    .BASE_SECONDS(5),
    .MAX_LEVEL(3),
    .SEC_W(8)
  ) dut (
    .clk(clk),
    .system_reset(system_reset),
    .sleep(sleep),
    .correct_password(correct_password),
    .end_sleep(end_sleep),
    .sleeping(sleeping),
    .secs_left(secs_left),
    .lock_level(lock_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (end_sleep === 1'b1) pulses++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full lockout from IDLE: raise sleep, check load, first decrement,
  // the expiry edge, and that exactly one pulse appears; then release sleep.
  task automatic lockout(input string tag, input int d, input int lvl_after,
                         input bit cp_at_exp, input int hold);
    int p0;
    p0 = pulses;
    sleep = 1'b1;
    step(1);
    chk({tag, " load"}, secs_left, d);
    chk({tag, " sleeping"}, sleeping, 1);
    step(3);
    chk({tag, " pre-tick"}, secs_left, d);
    step(1);
    chk({tag, " first dec"}, secs_left, d - 1);
    step(4 * d - 5);
    chk({tag, " last sec"}, secs_left, 1);
    chk({tag, " no early pulse"}, end_sleep, 0);
    if (cp_at_exp) correct_password = 1'b1;
    step(1);
    correct_password = 1'b0;
    chk({tag, " end_sleep"}, end_sleep, 1);
    chk({tag, " secs zero"}, secs_left, 0);
    chk({tag, " level"}, lock_level, lvl_after);
    chk({tag, " not sleeping"}, sleeping, 0);
    step(1);
    chk({tag, " pulse low"}, end_sleep, 0);
    if (hold > 0) step(hold);
    sleep = 1'b0;
    step(2);
    chk({tag, " one pulse"}, pulses - p0, 1);
  endtask

  initial begin
    int p0;
    total_cnt = 0;
    pass_cnt  = 0;
    fail_cnt  = 0;
    pulses    = 0;
    system_reset     = 1'b1;
    sleep            = 1'b0;
    correct_password = 1'b0;
    step(2);
    system_reset = 1'b0;
    step(1);
    chk("reset secs", secs_left, 0);
    chk("reset sleeping", sleeping, 0);
    chk("reset end", end_sleep, 0);
    chk("reset level", lock_level, 0);

    // Basic lockout plus escalation/saturation
    lockout("lk5", 5, 1, 1'b0, 0);
    lockout("lk10", 10, 2, 1'b0, 0);
    lockout("lk20", 20, 3, 1'b0, 0);
    lockout("lk40a", 40, 3, 1'b0, 0);
    lockout("lk40b", 40, 3, 1'b0, 0);

    // Clear
    correct_password = 1'b1;
    step(1);
    correct_password = 1'b0;
    chk("clear from 3", lock_level, 0);
    lockout("clr5", 5, 1, 1'b0, 0);
    lockout("clr10", 10, 2, 1'b0, 0);
    correct_password = 1'b1;
    step(1);
    correct_password = 1'b0;
    chk("clear from 2", lock_level, 0);
    lockout("cpexp", 5, 0, 1'b1, 0);
    lockout("after cpexp", 5, 1, 1'b0, 0);

    // Abort at secs_left = 3
    p0 = pulses;
    sleep = 1'b1;
    step(1);
    chk("abort load", secs_left, 10);
    step(28);
    chk("abort at 3", secs_left, 3);
    sleep = 1'b0;
    step(1);
    chk("abort secs", secs_left, 0);
    chk("abort sleeping", sleeping, 0);
    chk("abort end", end_sleep, 0);
    chk("abort level", lock_level, 1);
    step(10);
    chk("abort no pulse", pulses - p0, 0);
    sleep = 1'b1;
    step(1);
    chk("restart load", secs_left, 10);
    step(6);
    chk("restart dec", secs_left, 9);
    sleep = 1'b0;
    step(2);

    // Held sleep produces only one pulse
    lockout("held", 10, 2, 1'b0, 100);

    // Reset mid-count
    p0 = pulses;
    sleep = 1'b1;
    step(1);
    chk("rst load", secs_left, 20);
    step(10);
    system_reset = 1'b1;
    step(1);
    system_reset = 1'b0;
    sleep = 1'b0;
    chk("rst secs", secs_left, 0);
    chk("rst sleeping", sleeping, 0);
    chk("rst end", end_sleep, 0);
    chk("rst level", lock_level, 0);
    step(100);
    chk("rst no pulse", pulses - p0, 0);
    chk("rst stays idle", sleeping, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sleep_timer.md
# sleep_timer

Lockout timer that sits directly downstream of the Controller's `sleep` output and feeds its `end_sleep` input. While the Controller holds `sleep` high after a rejected code, this block counts down a lockout period measured in whole seconds of `clk` and then pulses `end_sleep` for one cycle. Each consecutive completed lockout doubles the period, up to a saturation level. A `correct_password` pulse from code_checker clears the escalation. It also exposes the remaining seconds for the display panel.

## Interface
- `CLK_HZ`, 50_000_000: `clk` cycles per second (the bench overrides this to a small value).
- `BASE_SECONDS`, 5: lockout length at escalation level 0.
- `MAX_LEVEL`, 3: saturation value of the escalation level. Must satisfy BASE_SECONDS << MAX_LEVEL ≤ 2^SEC_W − 1.
- `SEC_W`, 8: width of the seconds counter.
- `clk` in 1: system clock (CLOCK_50 at top level).
- `system_reset` in 1: one clock; reset is synchronous and active-high.
- `sleep` in 1: level from the Controller; high while the Controller is in its sleep state.
- `correct_password` in 1: one-cycle pulse from code_checker; clears the escalation level.
- `end_sleep` out 1: registered one-cycle pulse; lockout period has elapsed.
- `sleeping` out 1: high while the countdown is running (state COUNT).
- `secs_left` out SEC_W: remaining whole seconds; 0 when not counting.
- `lock_level` out 2 (minimum; sized as clog2(MAX_LEVEL+1)): current escalation level.

## Operation
- **States:**
  - IDLE: if `sleep`=1, go to COUNT.
  - COUNT: go to WAIT_RELEASE on expiry; go to IDLE if `sleep`=0.
  - WAIT_RELEASE: go to IDLE once `sleep`=0.
- **IDLE → COUNT:**
  - `secs_left` ← BASE_SECONDS << `lock_level`.
  - Prescaler ← 0.
- **Prescaler in COUNT:**
  - Counts 0..CLK_HZ−1 and wraps.
  - A tick occurs on the cycle where prescaler = CLK_HZ−1.
  - On each tick, `secs_left` decrements.
- **Expiry:** a tick with `secs_left`=1 in COUNT causes, on the same edge:
  - `secs_left` ← 0;
  - `end_sleep` ← 1 for exactly one cycle;
  - `lock_level` ← min(`lock_level`+1, MAX_LEVEL);
  - state ← WAIT_RELEASE.
- **Abort:** if `sleep` drops during COUNT:
  - go to IDLE, `secs_left` ← 0, prescaler ← 0;
  - no `end_sleep`, `lock_level` unchanged.
- **WAIT_RELEASE:** ignores ticks and never re-arms. A new lockout requires `sleep` to go low and then high again. A `sleep` that stays high therefore produces exactly one `end_sleep`.
- **`correct_password`:** `lock_level` ← 0 in any state. If it coincides with the expiry increment, the clear wins (result 0).
  - In COUNT, the running countdown is not shortened.
- **Width rules:**
  - `lock_level` saturates at MAX_LEVEL; it never wraps.
  - `secs_left` never underflows; decrement happens only when the value is ≥1.

## Timing
- **Reset values:** state IDLE; `secs_left`=0; `end_sleep`=0; `sleeping`=0; `lock_level`=0; prescaler=0.
- **Reset priority:** reset overrides all inputs on the same edge. Reset mid-COUNT gives IDLE with no `end_sleep`.
- **Start:** `sleep` sampled high at edge k in IDLE gives `sleeping`=1 and `secs_left`=D from edge k+1, where D = BASE_SECONDS << `lock_level`.
- **First decrement:** at edge k+CLK_HZ+1.
- **Expiry:** `end_sleep`=1 during the cycle after edge k+1+D·CLK_HZ; low again one cycle later.
- **Outputs:** all are registered. There is no combinational path from any input to any output.
- **`lock_level` update:** visible on the same edge as `end_sleep` rises.

## Test plan
Bench uses CLK_HZ=4, BASE_SECONDS=5, MAX_LEVEL=3.
1. **Basic lockout.** Reset, then raise `sleep` and hold it → `secs_left`=5 one cycle later, decrementing every 4 cycles. Exactly one `end_sleep` pulse 21 cycles after `sleep` is sampled; then `lock_level`=1 and `secs_left`=0.
2. **Escalation and saturation.** Four back-to-back lockouts, with `sleep` dropped for 2 cycles between them → loaded durations 5, 10, 20, 40. A fifth lockout loads 40 again with `lock_level`=3.
3. **Clear.** After two lockouts (`lock_level`=2), pulse `correct_password` → `lock_level`=0 and the next lockout loads 5. Pulsing it on the expiry cycle leaves `lock_level`=0.
4. **Abort.** Drop `sleep` at `secs_left`=3 → `secs_left`=0 and `sleeping`=0 next cycle, no `end_sleep`, `lock_level` unchanged. A restart reloads the full duration.
5. **Held sleep and reset.** Keep `sleep` high for 100 cycles after expiry → only one `end_sleep`. Separately, assert `system_reset` mid-COUNT → all outputs return to reset values the next cycle and no pulse follows.
